// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: one radix-2 restoring step per cycle on operand magnitudes.
// Signs are applied on the edge entering DONE, so hi/lo only ever hold committed results.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; start & ~annul latches operands, counter=31
// BUSY  | one restoring step per cycle, counter counts down to 0
// DONE  | one-cycle result pulse (valid=1), stall released, back to IDLE
module div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sign,
  input  logic        annul,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        stall_div,
  output logic        valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  always_comb begin
    abs_a = (sign && srca[31]) ? (~srca + 32'd1) : srca;
    abs_b = (sign && srcb[31]) ? (~srcb + 32'd1) : srcb;
  end

  // The shifted partial remainder needs 33 bits; after a restoring step it
  // is always below the divisor (or equals the dividend prefix when dividing
  // by zero), so 32 bits are enough to store it between cycles.
  always_comb begin
    rem_sh = {rem, quo[31]};
    diff   = rem_sh - {1'b0, dvsr};
    if (diff[32]) begin
      rem_nxt = rem_sh[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end else begin
      rem_nxt = diff[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end
  end

  // Divide by zero naturally leaves the dividend magnitude as the remainder,
  // which the dividend-sign fix turns back into srca; only lo needs forcing.
  always_comb begin
    q_fin = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    r_fin = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;
    if (div_zero) begin
      q_fin = 32'hFFFF_FFFF;
    end
  end

  assign stall_div = rst_n && (((state == IDLE) && start && !annul) || (state == BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvsr     <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      valid    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            rem      <= 32'd0;
            quo      <= abs_a;
            dvsr     <= abs_b;
            neg_q    <= sign && (srca[31] ^ srcb[31]);
            neg_r    <= sign && srca[31];
            div_zero <= (srcb == 32'd0);
            cnt      <= 5'd31;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (annul) begin
            cnt   <= 5'd0;
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == 5'd0) begin
              hi    <= r_fin;
              lo    <= q_fin;
              valid <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results are queued at start and
// popped when valid pulses; also checks stall length, annul and reset.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        stall_div;
  logic        valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .annul(annul),
    .srca(srca), .srcb(srcb), .stall_div(stall_div), .valid(valid),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drives one divide starting at the next falling edge, holds start while
  // stalled and scrambles operands after the start cycle. Returns in the
  // DONE cycle; start is left high when hold is set.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit hold);
    int stalls;
    int cyc;
    bit seen;
    logic [63:0] e;
    stalls = 0;
    cyc = 0;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    sign  = sgn;
    srca  = a;
    srcb  = b;
    sb_q.push_back(exp);
    while (cyc < 60 && !seen) begin
      #1;
      if (valid) begin
        seen = 1;
        e = sb_q.pop_front();
        chk({tag, " hi"}, hi, e[63:32]);
        chk({tag, " lo"}, lo, e[31:0]);
        chk({tag, " stall_in_done"}, {31'd0, stall_div}, 32'd0);
        chk({tag, " stall_cycles"}, stalls, 32'd33);
      end else begin
        if (stall_div) stalls++;
        @(negedge clk);
        srca = $urandom;
        srcb = $urandom;
        sign = ~sgn;
        cyc++;
      end
    end
    if (!seen) begin
      void'(sb_q.pop_front());
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end
    if (!hold) start = 1'b0;
  endtask

  initial begin
    bit saw_valid;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    #2;
    chk("reset stall", {31'd0, stall_div}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    @(negedge clk);
    #1;
    chk("valid one cycle", {31'd0, valid}, 32'd0);
    chk("hi held", hi, 32'd2);
    chk("lo held", lo, 32'd14);

    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_div("u5_0", 1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    run_div("s_neg_0", 1'b1, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0);
    run_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 0);

    // back-to-back with start held through DONE
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 2) ? 32'd0 : ($urandom >> (i * 5));
      rs = i[0];
      run_div("b2b", rs, ra, rb, model(rs, ra, rb), i != 5);
    end

    run_div("u100_7b", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    @(negedge clk);
    start = 1'b1;
    sign  = 1'b0;
    srca  = 32'd50;
    srcb  = 32'd3;
    for (int i = 0; i < 10; i++) @(negedge clk);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul stall", {31'd0, stall_div}, 32'd0);
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (valid) saw_valid = 1;
    end
    chk("annul no valid", {31'd0, saw_valid}, 32'd0);
    chk("annul hi kept", hi, 32'd2);
    chk("annul lo kept", lo, 32'd14);

    @(negedge clk);
    start = 1'b1;
    annul = 1'b1;
    #1;
    chk("idle annul stall", {31'd0, stall_div}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b0;
    #1;
    chk("idle annul no start", {31'd0, stall_div}, 32'd0);

    @(negedge clk);
    start = 1'b1;
    sign  = 1'b0;
    srca  = 32'd1000;
    srcb  = 32'd9;
    for (int i = 0; i < 20; i++) @(negedge clk);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst busy stall", {31'd0, stall_div}, 32'd0);
    chk("rst busy valid", {31'd0, valid}, 32'd0);
    chk("rst busy hi", hi, 32'd0);
    chk("rst busy lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("done annul lo", lo, 32'd3);
    chk("done annul valid", {31'd0, valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
